// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin register-file write-back arbiter with RAW scoreboard
//
// Purpose:
//   Shares the single integer register-file write port between N_SRC
//   write-back sources using round-robin arbitration. The winner is
//   registered onto the write port one cycle after its handshake. A
//   per-register pending scoreboard lets the issue stage stall on RAW
//   hazards against results that have not yet been written back.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   src_valid    [N_SRC]       source i offers a write-back
//   src_rd       [N_SRC*AW]    dest index of source i, slice [i*AW +: AW]
//   src_data     [N_SRC*XLEN]  result of source i, slice [i*XLEN +: XLEN]
//   src_ready    [N_SRC]       one-hot grant, handshake = valid & ready
//   we           register-file write enable (registered)
//   wb_rd        register-file write index (registered)
//   rddata       register-file write data (registered)
//   alloc_valid  issue stage allocates a destination register
//   alloc_rd     index being allocated
//   flush        clears the scoreboard (a same-cycle alloc still sets)
//   rs1, rs2     source register indices being decoded
//   rs1_busy     rs1 has a pending write-back
//   rs2_busy     rs2 has a pending write-back
//   rs1_fwd      (WB_BYPASS_EN only) rs1 is being written this cycle
//   rs2_fwd      (WB_BYPASS_EN only) rs2 is being written this cycle
//
// Optional feature:
//   WB_BYPASS_EN  adds rs1_fwd/rs2_fwd and drops busy during the write
//                 cycle so the operand can be taken from rddata.
module regfile_wb_arbiter #(
  parameter int N_SRC = 3,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*AW-1:0]   src_rd,
  input  logic [N_SRC*XLEN-1:0] src_data,
  output logic [N_SRC-1:0]      src_ready,
  output logic                  we,
  output logic [AW-1:0]         wb_rd,
  output logic [XLEN-1:0]       rddata,
  input  logic                  alloc_valid,
  input  logic [AW-1:0]         alloc_rd,
  input  logic                  flush,
  input  logic [AW-1:0]         rs1,
  input  logic [AW-1:0]         rs2,
`ifdef WB_BYPASS_EN
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
`endif
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int PW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [N_SRC-1:0] grant;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    idx;
  logic             found;
  logic             hs;
  logic [AW-1:0]    sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;

  // Scan from ptr upward with wrap; the first valid source wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = PW'((int'(ptr) + k) % N_SRC);
      if (!found && src_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  // Grants are suppressed while reset is asserted so no source sees a
  // handshake that the (held) write port can never honour.
  assign src_ready = rst ? grant : '0;
  assign hs        = rst & found;

  // grant is one-hot, so this reduces to a plain select of the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        sel_rd   = src_rd[i*AW +: AW];
        sel_data = src_data[i*XLEN +: XLEN];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;

  // Clear happens the cycle the write lands on the port; an alloc to the
  // same index in that cycle is a fresh producer, so set wins. Flush drops
  // everything but still honours a same-cycle alloc.
  always_comb begin
    pending_nxt = pending;
    if (flush) begin
      pending_nxt = '0;
    end else if (we && (wb_rd != '0)) begin
      pending_nxt[wb_rd] = 1'b0;
    end
    if (alloc_valid && (alloc_rd != '0)) begin
      pending_nxt[alloc_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      we      <= 1'b0;
      wb_rd   <= '0;
      rddata  <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (hs) begin
        ptr    <= ptr_nxt;
        // x0 writes still consume a grant but never reach the file.
        we     <= (sel_rd != '0);
        wb_rd  <= sel_rd;
        rddata <= sel_data;
      end else begin
        we <= 1'b0;
      end
    end
  end

  // pending[0] is held at zero, so rs==0 reads as not busy without a compare.
`ifdef WB_BYPASS_EN
  assign rs1_fwd  = we && (wb_rd != '0) && (wb_rd == rs1);
  assign rs2_fwd  = we && (wb_rd != '0) && (wb_rd == rs2);
  assign rs1_busy = pending[rs1] && !rs1_fwd;
  assign rs2_busy = pending[rs2] && !rs2_fwd;
`else
  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
  } rr_vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      src_valid;
  logic [N*AW-1:0]   src_rd;
  logic [N*XLEN-1:0] src_data;
  logic [N-1:0]      src_ready;
  logic              we;
  logic [AW-1:0]     wb_rd;
  logic [XLEN-1:0]   rddata;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_rd;
  logic              flush;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic              rs1_busy;
  logic              rs2_busy;
`ifdef WB_BYPASS_EN
  logic              rs1_fwd;
  logic              rs2_fwd;
`endif

  regfile_wb_arbiter #(.N_SRC(N), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data), .src_ready(src_ready),
    .we(we), .wb_rd(wb_rd), .rddata(rddata),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2),
`ifdef WB_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
`endif
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  bit            m_we;
  bit [AW-1:0]   m_rd;
  bit [XLEN-1:0] m_data;
  bit            m_pend [32];
  int            serial [N];
  rr_vec_t       tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endfunction

  function automatic int exp_grant();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (src_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input bit v, input bit [AW-1:0] rd, input bit [XLEN-1:0] d);
    src_valid[i]           = v;
    src_rd[i*AW +: AW]     = rd;
    src_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic check_outputs();
    int           g;
    logic [N-1:0] er;
    bit           eb1;
    bit           eb2;
    g  = exp_grant();
    er = '0;
    if (rst && g >= 0) er[g] = 1'b1;
    chk("src_ready", src_ready, er);
    chk("we", we, m_we);
    chk("wb_rd", wb_rd, m_rd);
    chk("rddata", rddata, m_data);
    eb1 = (rs1 != 0) && m_pend[rs1];
    eb2 = (rs2 != 0) && m_pend[rs2];
`ifdef WB_BYPASS_EN
    begin
      bit f1;
      bit f2;
      f1 = m_we && (m_rd != 0) && (m_rd == rs1);
      f2 = m_we && (m_rd != 0) && (m_rd == rs2);
      chk("rs1_fwd", rs1_fwd, f1);
      chk("rs2_fwd", rs2_fwd, f2);
      eb1 = eb1 && !f1;
      eb2 = eb2 && !f2;
    end
`endif
    chk("rs1_busy", rs1_busy, eb1);
    chk("rs2_busy", rs2_busy, eb2);
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
  endtask

  // Commit the model for the coming rising edge, then step past it.
  task automatic advance(output int g);
    g = -1;
    if (rst) begin
      g = exp_grant();
      assert (!(alloc_valid && alloc_rd != 0 && m_pend[alloc_rd]))
        else $error("stimulus allocates pending register %0d", alloc_rd);
      if (flush) foreach (m_pend[i]) m_pend[i] = 1'b0;
      else if (m_we && m_rd != 0) m_pend[m_rd] = 1'b0;
      if (alloc_valid && alloc_rd != 0) m_pend[alloc_rd] = 1'b1;
      if (g >= 0) begin
        m_rd   = src_rd[g*AW +: AW];
        m_data = src_data[g*XLEN +: XLEN];
        m_we   = (m_rd != 0);
        m_ptr  = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            g;
    bit            prev_any;
    logic [XLEN-1:0] prev_data;
    int            r;

    src_valid = '0; src_rd = '0; src_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0; rs1 = '0; rs2 = '0;
    model_reset();
    foreach (serial[i]) serial[i] = 0;
    prev_any  = 1'b0;
    prev_data = '0;

    tbl = '{
      '{3'b111, 3'b001}, '{3'b111, 3'b010}, '{3'b111, 3'b100},
      '{3'b111, 3'b001}, '{3'b111, 3'b010}, '{3'b111, 3'b100},
      '{3'b011, 3'b001}, '{3'b010, 3'b010}, '{3'b000, 3'b000},
      '{3'b001, 3'b001}, '{3'b101, 3'b100}, '{3'b001, 3'b001},
      '{3'b110, 3'b010}, '{3'b100, 3'b100}, '{3'b000, 3'b000}
    };

    // Reset state
    sample();
    chk("reset_we", we, 1'b0);
    chk("reset_ready", src_ready, 3'b000);
    advance(g);
    rst = 1'b1;

    // Reset mid-traffic
    alloc_valid = 1'b1; alloc_rd = 5'd12;
    advance(g);
    alloc_valid = 1'b0; rs1 = 5'd12;
    sample();
    chk("busy_before_reset", rs1_busy, 1'b1);
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(i + 20), 32'h1000 + i);
    advance(g);
    advance(g);
    rst = 1'b0;
    #1;
    chk("mid_reset_we", we, 1'b0);
    chk("mid_reset_ready", src_ready, 3'b000);
    chk("mid_reset_busy", rs1_busy, 1'b0);
    model_reset();
    sample();
    advance(g);
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      sample();
      chk("post_reset_grant", src_ready, 64'(1 << k));
      advance(g);
      if (g >= 0) set_src(g, 1'b0, '0, '0);
    end

    // Round-robin table
    for (r = 0; r < 15; r++) begin
      for (int i = 0; i < N; i++)
        set_src(i, tbl[r].valid[i], AW'(i + 10), {8'(i), 24'(serial[i])});
      sample();
      chk("rr_grant", src_ready, tbl[r].ready);
      if (r > 0) begin
        chk("rr_we", we, prev_any);
        if (prev_any) chk("rr_data", rddata, prev_data);
      end
      prev_any = |tbl[r].ready;
      for (int i = 0; i < N; i++)
        if (tbl[r].ready[i]) prev_data = {8'(i), 24'(serial[i])};
      advance(g);
      if (g >= 0) serial[g]++;
    end

    // x0 write
    set_src(0, 1'b1, 5'd0, 32'hDEAD);
    sample();
    chk("x0_grant", src_ready, 3'b001);
    advance(g);
    set_src(0, 1'b0, '0, '0);
    sample();
    chk("x0_we", we, 1'b0);

    // Scoreboard set / clear through a write-back
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    advance(g);
    alloc_valid = 1'b0; rs1 = 5'd5;
    sample();
    chk("sb_busy_set", rs1_busy, 1'b1);
    set_src(1, 1'b1, 5'd5, 32'h5555);
    advance(g);
    set_src(1, 1'b0, '0, '0);
    sample();
    chk("sb_we", we, 1'b1);
    chk("sb_wb_rd", wb_rd, 5'd5);
`ifdef WB_BYPASS_EN
    chk("sb_busy_we_cycle", rs1_busy, 1'b0);
    chk("sb_fwd_we_cycle", rs1_fwd, 1'b1);
`else
    chk("sb_busy_we_cycle", rs1_busy, 1'b1);
`endif
    advance(g);
    sample();
    chk("sb_busy_after", rs1_busy, 1'b0);

    // Set/clear collision on rd=7
    set_src(2, 1'b1, 5'd7, 32'h7777);
    advance(g);
    set_src(2, 1'b0, '0, '0);
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    sample();
    chk("coll_wb_rd", wb_rd, 5'd7);
    advance(g);
    alloc_valid = 1'b0; rs2 = 5'd7;
    sample();
    chk("coll_pending", rs2_busy, 1'b1);

    // Flush with same-cycle alloc and a late write-back
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    advance(g);
    alloc_rd = 5'd9;
    advance(g);
    flush = 1'b1; alloc_rd = 5'd4;
    set_src(0, 1'b1, 5'd3, 32'h0333);
    advance(g);
    flush = 1'b0; alloc_valid = 1'b0;
    set_src(0, 1'b0, '0, '0);
    rs1 = 5'd3; rs2 = 5'd9;
    sample();
    chk("flush_late_we", we, 1'b1);
    chk("flush_late_rd", wb_rd, 5'd3);
    chk("flush_busy3", rs1_busy, 1'b0);
    chk("flush_busy9", rs2_busy, 1'b0);
    rs1 = 5'd4; rs2 = 5'd7;
    #1;
    chk("flush_busy4", rs1_busy, 1'b1);
    chk("flush_busy7", rs2_busy, 1'b0);
    advance(g);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int ar;
      for (int i = 0; i < N; i++)
        if (!src_valid[i] && $urandom_range(1, 0) == 1)
          set_src(i, 1'b1, AW'($urandom_range(31, 0)), $urandom);
      alloc_valid = 1'b0;
      if ($urandom_range(2, 0) == 0) begin
        ar = $urandom_range(31, 0);
        if (!m_pend[ar]) begin
          alloc_valid = 1'b1;
          alloc_rd    = AW'(ar);
        end
      end
      flush = ($urandom_range(39, 0) == 0);
      rs1   = AW'($urandom_range(31, 0));
      rs2   = AW'($urandom_range(31, 0));
      sample();
      advance(g);
      if (g >= 0) src_valid[g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
